// File: rtl/tile_read_sequencer_if.sv
// Read-side port bundle for tile_read_sequencer: launch/backpressure controls
// toward the sequencer, bank read enables/addresses and status back out.
interface tile_read_sequencer_if #(
    parameter int unsigned SIZE   = 8,
    parameter int unsigned ADDR_W = 10
);
    logic                     start;
    logic [ADDR_W-1:0]        base_addr;
    logic [ADDR_W-1:0]        row_count;
    logic                     hold;
    logic [SIZE-1:0]          enb;
    logic [SIZE*ADDR_W-1:0]   addrb;
    logic [SIZE-1:0]          lane_valid;
    logic                     busy;
    logic                     done;

    modport master (
        output start, base_addr, row_count, hold,
        input  enb, addrb, lane_valid, busy, done
    );

    modport slave (
        input  start, base_addr, row_count, hold,
        output enb, addrb, lane_valid, busy, done
    );
endinterface

// File: rtl/tile_read_sequencer.sv
// Skewed (systolic) read address generator for the banked tile buffer:
// lane i reads row r one cycle after lane i-1, with hold-based backpressure.
module tile_read_sequencer #(
    parameter int unsigned SIZE   = 8,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                 clock,
    input  logic                 reset_n,
    tile_read_sequencer_if.slave bus
);
    // Wide enough for row_count + SIZE - 2 without wrapping.
    localparam int unsigned CW = ADDR_W + $clog2(SIZE) + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StFlush} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       t_q, t_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   rc_q, rc_d;
    logic [SIZE-1:0]     lane_valid_q;
    logic [SIZE-1:0]     enb_c;
    logic [SIZE*ADDR_W-1:0] addr_c;
    logic [CW-1:0]       t_last;

    assign t_last = CW'(rc_q) + CW'(SIZE - 2);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            t_q          <= '0;
            base_q       <= '0;
            rc_q         <= '0;
            lane_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            base_q       <= base_d;
            rc_q         <= rc_d;
            lane_valid_q <= enb_c;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        base_d  = base_q;
        rc_d    = rc_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    base_d  = bus.base_addr;
                    rc_d    = bus.row_count;
                    t_d     = '0;
                    state_d = (bus.row_count != '0) ? StIssue : StFlush;
                end
            end
            StIssue: begin
                if (!bus.hold) begin
                    if (t_q == t_last) begin
                        state_d = StFlush;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
            end
            StFlush: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Lane i is active while its own row index (t - i) lies in [0, row_count).
    always_comb begin
        enb_c  = '0;
        addr_c = '0;
        if (state_q == StIssue && !bus.hold) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                if (t_q >= CW'(i) && t_q < CW'(i) + CW'(rc_q)) begin
                    enb_c[i]                    = 1'b1;
                    addr_c[i*ADDR_W +: ADDR_W] = base_q + ADDR_W'(t_q - CW'(i));
                end
            end
        end
    end

    assign bus.enb        = enb_c;
    assign bus.addrb      = addr_c;
    assign bus.lane_valid = lane_valid_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = (state_q == StFlush);
endmodule

// File: tb/tb_tile_read_sequencer.sv
// Bench for tile_read_sequencer: constant vector table, directed corner
// sequences and randomized runs against a row-position reference model.
module tb_tile_read_sequencer;
    localparam int unsigned SIZE = 8;
    localparam int unsigned AW   = 10;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    tile_read_sequencer_if #(.SIZE(SIZE), .ADDR_W(AW)) bus ();

    tile_read_sequencer #(.SIZE(SIZE), .ADDR_W(AW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Sampled DUT outputs of the most recent cycle.
    logic [SIZE-1:0]    s_enb, s_lv;
    logic [SIZE*AW-1:0] s_addr;
    logic               s_busy, s_done;

    // Reference model: pos = -1 idle, 0..len-1 issue step, len = flush.
    int m_pos = -1;
    int m_len = 0;
    int m_base = 0;
    int m_rc = 0;
    logic [SIZE-1:0] m_prev_enb = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic st, input logic [AW-1:0] b, input logic [AW-1:0] r,
                        input logic h);
        logic [SIZE-1:0]    e_enb;
        logic [SIZE*AW-1:0] e_addr;
        logic               e_busy, e_done;
        @(negedge clock);
        bus.start = st; bus.base_addr = b; bus.row_count = r; bus.hold = h;
        #1;
        s_enb = bus.enb; s_addr = bus.addrb; s_lv = bus.lane_valid;
        s_busy = bus.busy; s_done = bus.done;
        e_enb = '0; e_addr = '0;
        if (m_pos >= 0 && m_pos < m_len && !h) begin
            for (int i = 0; i < int'(SIZE); i++) begin
                if (i <= m_pos && m_pos < i + m_rc) begin
                    e_enb[i] = 1'b1;
                    e_addr[i*AW +: AW] = AW'((m_base + m_pos - i) % (1 << AW));
                end
            end
        end
        e_busy = (m_pos >= 0);
        e_done = (m_pos >= 0 && m_pos == m_len);
        chk("model", {s_enb, s_addr, s_lv, s_busy, s_done},
            {e_enb, e_addr, m_prev_enb, e_busy, e_done});
        @(posedge clock);
        m_prev_enb = e_enb;
        if (m_pos < 0) begin
            if (st) begin
                m_base = int'(b); m_rc = int'(r);
                m_len  = (r == 0) ? 0 : int'(r) + int'(SIZE) - 1;
                m_pos  = 0;
            end
        end else if (m_pos == m_len) begin
            m_pos = -1;
        end else if (!h) begin
            m_pos++;
        end
    endtask

    typedef struct {
        logic st; logic [AW-1:0] b; logic [AW-1:0] r; logic h;
        logic [SIZE-1:0] enb; logic [SIZE-1:0] lv; logic busy; logic done;
        logic [AW-1:0] a0; logic [AW-1:0] a7;
    } vec_t;

    function automatic vec_t mk(logic st, int b, int r, logic [SIZE-1:0] enb,
                                logic [SIZE-1:0] lv, logic busy, logic done, int a0, int a7);
        vec_t v;
        v.st = st; v.b = AW'(b); v.r = AW'(r); v.h = 1'b0;
        v.enb = enb; v.lv = lv; v.busy = busy; v.done = done;
        v.a0 = AW'(a0); v.a7 = AW'(a7);
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        // Rows 0..13: base 0, 4 rows; rows 14..16: zero-row launch.
        tbl[0]  = mk(1, 0, 4, 8'h00, 8'h00, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 8'h01, 8'h00, 1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 8'h03, 8'h01, 1, 0, 1, 0);
        tbl[3]  = mk(0, 0, 0, 8'h07, 8'h03, 1, 0, 2, 0);
        tbl[4]  = mk(0, 0, 0, 8'h0F, 8'h07, 1, 0, 3, 0);
        tbl[5]  = mk(0, 0, 0, 8'h1E, 8'h0F, 1, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 8'h3C, 8'h1E, 1, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 8'h78, 8'h3C, 1, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 8'hF0, 8'h78, 1, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 8'hE0, 8'hF0, 1, 0, 0, 1);
        tbl[10] = mk(0, 0, 0, 8'hC0, 8'hE0, 1, 0, 0, 2);
        tbl[11] = mk(0, 0, 0, 8'h80, 8'hC0, 1, 0, 0, 3);
        tbl[12] = mk(0, 0, 0, 8'h00, 8'h80, 1, 1, 0, 0);
        tbl[13] = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        tbl[14] = mk(1, 7, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0);
        tbl[16] = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);

        bus.start = 0; bus.base_addr = '0; bus.row_count = '0; bus.hold = 0;
        reset_n = 1'b0;
        #12;
        chk("reset_state", {bus.enb, bus.addrb, bus.lane_valid, bus.busy, bus.done}, '0);
        #5 reset_n = 1'b1;

        foreach (tbl[j]) begin
            tick(tbl[j].st, tbl[j].b, tbl[j].r, tbl[j].h);
            chk("tbl_enb", s_enb, tbl[j].enb);
            chk("tbl_lv", s_lv, tbl[j].lv);
            chk("tbl_busy_done", {s_busy, s_done}, {tbl[j].busy, tbl[j].done});
            chk("tbl_addr0", s_addr[0 +: AW], tbl[j].a0);
            chk("tbl_addr7", s_addr[7*AW +: AW], tbl[j].a7);
        end

        // Address wrap: every lane issues 1022, 1023, 0.
        for (int j = 0; j <= 12; j++) begin
            tick(j == 0, 10'd1022, 10'd3, 1'b0);
            if (j == 1) chk("wrap_a0_first", s_addr[0 +: AW], 1022);
            if (j == 3) chk("wrap_a0_last", s_addr[0 +: AW], 0);
            if (j == 8) chk("wrap_a7_first", s_addr[7*AW +: AW], 1022);
            if (j == 10) chk("wrap_a7_last", s_addr[7*AW +: AW], 0);
        end

        // Hold during cycles 3-4 delays done from 10 to 12.
        for (int j = 0; j <= 13; j++) begin
            tick(j == 0, 10'd5, 10'd2, j == 3 || j == 4);
            if (j == 3 || j == 4) chk("hold_quiet", {s_enb, s_addr}, '0);
            if (j == 4 || j == 5) chk("hold_lv_low", s_lv, '0);
            if (j == 5) begin
                chk("hold_resume_enb", s_enb, 8'h06);
                chk("hold_resume_a1", s_addr[1*AW +: AW], 6);
                chk("hold_resume_a2", s_addr[2*AW +: AW], 5);
            end
            if (j >= 1) chk("hold_done", s_done, j == 12);
        end

        // start mid-sequence with different base/row_count is ignored.
        for (int j = 0; j <= 13; j++) begin
            tick(j == 0 || j == 3, (j == 3) ? 10'd200 : 10'd0, (j == 3) ? 10'd9 : 10'd4, 1'b0);
            if (j == 4) chk("ignore_a0", s_addr[0 +: AW], 3);
            if (j >= 1) chk("ignore_done", s_done, j == 12);
        end

        // Asynchronous reset mid-issue, then a single-row launch.
        for (int j = 0; j <= 3; j++) tick(j == 0, 10'd50, 10'd6, 1'b0);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1 chk("async_reset", {bus.enb, bus.addrb, bus.lane_valid, bus.busy, bus.done}, '0);
        @(posedge clock);
        @(negedge clock);
        #2 reset_n = 1'b1;
        m_pos = -1; m_prev_enb = '0;
        for (int j = 0; j <= 10; j++) begin
            tick(j == 0, 10'd100, 10'd1, 1'b0);
            if (j == 1) chk("post_reset_lane0", {s_enb, s_addr[0 +: AW]}, {8'h01, 10'd100});
            if (j >= 1) chk("post_reset_done", s_done, j == int'(SIZE) + 1);
        end

        // Randomized launches with random hold and stray start pulses.
        for (int n = 0; n < 40; n++) begin
            int rc;
            int k;
            rc = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
            if (n == 20) rc = int'($urandom_range(1000, 1023));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick(0, '0, '0, $urandom_range(0, 1));
            tick(1, AW'($urandom_range(0, 1023)), AW'(rc), $urandom_range(0, 1));
            k = 0;
            while (m_pos >= 0 && k < 3000) begin
                tick($urandom_range(0, 3) == 0, AW'($urandom_range(0, 1023)),
                     AW'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
                k++;
            end
            if (k >= 3000) chk("random_timeout", 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tile_read_sequencer.md
Name: tile_read_sequencer

Overview:
- Read-side address generator for the 8-bank tile buffer: drives per-bank read enables and packed read addresses so that tile rows stream out with a diagonal (systolic) skew.
- Bank i reads row r one cycle after bank i-1 does.
- Also produces per-lane valid flags aligned to the 1-cycle BRAM read latency, plus busy/done status for the tile controller.

Parameters:
- SIZE, 8, number of banks/lanes (one tile_buffer port-B read port per lane)
- ADDR_W, 10, per-bank address width; addresses wrap modulo 2^ADDR_W

Ports:
- clock  input  1  sole clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  launch a tile read; sampled only in IDLE
- base_addr  input  ADDR_W  first row address, captured with start
- row_count  input  ADDR_W  number of rows per lane, captured with start (0 legal)
- hold  input  1  downstream backpressure; freezes issue while high
- enb  output  SIZE  per-bank read enable, to tile_buffer enb
- addrb  output  SIZE*ADDR_W  packed read addresses, lane i at bits [i*ADDR_W +: ADDR_W]
- lane_valid  output  SIZE  lane i of doutb holds valid data this cycle
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse when the final lane data is valid

Behaviour:
- Reset (async, any time including mid-sequence) puts the FSM in IDLE and clears all outputs: enb=0, addrb=0, lane_valid=0, busy=0, done=0, and clears internal counters. After release, the block waits for a new start.
- States:
  - IDLE: start=1 at an edge captures base_addr and row_count, clears the issue counter t. Go to ISSUE if row_count≠0, else FLUSH.
  - ISSUE: lasts row_count+SIZE-1 non-held cycles, t = 0 .. row_count+SIZE-2. After the non-held cycle with t = row_count+SIZE-2, go to FLUSH.
  - FLUSH: exactly one cycle, then IDLE.
- Issue rule, in the ISSUE cycle with counter t and hold=0:
  - enb[i]=1 iff i ≤ t < i+row_count.
  - addrb lane i = (base + t − i) mod 2^ADDR_W when enabled, else 0.
- Hold:
  - With hold=1 in ISSUE: all enb=0, all addrb=0, t frozen, state unchanged.
  - hold is ignored in IDLE and FLUSH.
- Latency:
  - enb/addrb first assert in the cycle right after the edge that sampled start.
  - lane_valid is enb delayed by exactly one cycle (registered), so it is aligned with doutb.
  - lane_valid from the last ISSUE cycle appears during FLUSH.
- busy: high from the cycle after start is accepted through FLUSH inclusive; low in IDLE.
- done:
  - Pulses high only during FLUSH.
  - With row_count=0, done pulses in the cycle after start, with no enb ever asserted.
- start while busy is ignored; no queuing. start held high continuously relaunches on the first IDLE cycle after FLUSH.
- Captured base/row_count are unaffected by input changes during a sequence.
- All address arithmetic is ADDR_W bits, unsigned, modulo wrap; there is no error on wrap.
- Total cycles from start to done, with H held ISSUE cycles: row_count+SIZE+H (row_count>0).

Test Plan:
1. base=0, row_count=4, SIZE=8, start sampled at edge 0.
   - enb[0] high cycles 1–4 with addr 0,1,2,3.
   - enb[7] high cycles 8–11 with addr 0..3.
   - lane_valid[7] high cycles 9–12.
   - done=1 at cycle 12 only; busy cycles 1–12.
2. Wrap: base=1022, row_count=3 → every lane issues 1022, 1023, 0 in order, each lane offset by one cycle from the previous lane.
3. Hold: base=5, row_count=2, hold=1 during cycles 3–4.
   - Cycles 3–4: enb=0, addrb=0.
   - Cycle 5 resumes with the cycle-3 pattern (enb[1:2], addrs 6 / 5).
   - lane_valid low in cycles 4–5.
   - done moves from cycle 10 to cycle 12.
4. row_count=0 with start → busy=1 and done=1 in cycle 1, enb never asserted, IDLE in cycle 2.
5. start pulsed at cycle 3 of a running sequence with different base → ignored; original addresses continue and done timing is unchanged.
6. reset_n dropped asynchronously mid-ISSUE (between edges):
   - enb, addrb, lane_valid, busy, done go 0 immediately.
   - After release, a new start (base=100, row_count=1) produces enb[0] addr 100 one cycle later and done at cycle SIZE+1.
